// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NB_REQ requesters, with lock hold.
// Grant is combinational in the request cycle, rvalid one cycle later; mem_gnt_i low stalls.
module sram_port_arbiter #(
    parameter int NB_REQ     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ-1:0]              lock_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ-1:0]              we_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic                           mem_we_o,
    output logic [DATA_WIDTH/8-1:0]        mem_be_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               resp_pending_q, resp_pending_d;
    logic [PTR_W-1:0]   resp_id_q, resp_id_d;

    logic [PTR_W-1:0]   rr_winner;
    logic               rr_found;
    logic [PTR_W-1:0]   winner;
    logic               accept;
    int                 idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) >= NB_REQ - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // First requesting index at or above rr_ptr, wrapping modulo NB_REQ.
    always_comb begin
        rr_winner = rr_ptr_q;
        rr_found  = 1'b0;
        idx       = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NB_REQ) begin
                idx = idx - NB_REQ;
            end
            if (!rr_found && req_i[idx]) begin
                rr_found  = 1'b1;
                rr_winner = PTR_W'(idx);
            end
        end
    end

    // Outputs are forced idle while reset is asserted, even if requesters still hold req.
    always_comb begin
        winner    = (state_q == LOCKED) ? owner_q : rr_winner;
        mem_req_o = rst_n & ((state_q == LOCKED) ? req_i[owner_q] : rr_found);
        accept    = mem_req_o & mem_gnt_i;

        gnt_o = '0;
        if (accept) begin
            gnt_o[winner] = 1'b1;
        end

        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            mem_addr_o  = addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_we_o    = we_i[winner];
            mem_be_o    = be_i[int'(winner)*BE_W +: BE_W];
            mem_wdata_o = wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        end

        rvalid_o = '0;
        if (resp_pending_q) begin
            rvalid_o[resp_id_q] = 1'b1;
        end
        rdata_o = resp_pending_q ? mem_rdata_i : '0;
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        resp_pending_d = accept;
        resp_id_d      = accept ? winner : resp_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // A lock limit of one beat degenerates to an ordinary grant.
                    if (lock_i[winner] && (LOCK_MAX > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = winner;
                        lock_cnt_d = CNT_W'(1);
                    end else begin
                        rr_ptr_d = ptr_inc(winner);
                    end
                end
            end
            LOCKED: begin
                if (!req_i[owner_q]) begin
                    state_d    = IDLE;
                    rr_ptr_d   = ptr_inc(owner_q);
                    lock_cnt_d = '0;
                end else if (accept) begin
                    if (lock_cnt_q < CNT_MAX) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                    if (!lock_i[owner_q] || (lock_cnt_d == CNT_MAX)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = ptr_inc(owner_q);
                        lock_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            lock_cnt_q     <= '0;
            resp_pending_q <= 1'b0;
            resp_id_q      <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            lock_cnt_q     <= lock_cnt_d;
            resp_pending_q <= resp_pending_d;
            resp_id_q      <= resp_id_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: inputs change on falling edges, outputs sampled 1ns later.
module tb_sram_port_arbiter;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [NB-1:0]     req_i;
    logic [NB-1:0]     lock_i;
    logic [NB*AW-1:0]  addr_i;
    logic [NB-1:0]     we_i;
    logic [NB*BW-1:0]  be_i;
    logic [NB*DW-1:0]  wdata_i;
    logic [NB-1:0]     gnt_o;
    logic [NB-1:0]     rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [AW-1:0]     mem_addr_o;
    logic              mem_we_o;
    logic [BW-1:0]     mem_be_o;
    logic [DW-1:0]     mem_wdata_o;
    logic [DW-1:0]     mem_rdata_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [AW-1:0] A0 = 32'h1000_0100;
    localparam logic [AW-1:0] A1 = 32'h2000_0200;

    sram_port_arbiter #(
        .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .lock_i(lock_i), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_i       = 2'b11;
        lock_i      = 2'b00;
        addr_i      = {A1, A0};
        we_i        = 2'b00;
        be_i        = '1;
        wdata_i     = '0;
        mem_gnt_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", gnt_o); else pass_cnt++;
        chk_cnt++; if (rvalid_o !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", rvalid_o); else pass_cnt++;
        chk_cnt++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata_o); else pass_cnt++;
        chk_cnt++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); else pass_cnt++;
        @(negedge clk);
        req_i = 2'b00;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] exp_rv  [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [DW-1:0] rd;
        for (int k = 0; k < 5; k++) begin
            req_i       = (k < 4) ? 2'b11 : 2'b00;
            rd          = 32'hC0DE_0000 + DW'(k);
            mem_rdata_i = rd;
            #1;
            chk_cnt++; if (gnt_o !== exp_gnt[k]) $display("FAIL contention_gnt cyc=%0d got=%b exp=%b", k, gnt_o, exp_gnt[k]); else pass_cnt++;
            chk_cnt++; if (rvalid_o !== exp_rv[k]) $display("FAIL contention_rvalid cyc=%0d got=%b exp=%b", k, rvalid_o, exp_rv[k]); else pass_cnt++;
            if (k < 4) begin
                chk_cnt++; if (mem_addr_o !== (exp_gnt[k] == 2'b01 ? A0 : A1)) $display("FAIL contention_addr cyc=%0d got=%h", k, mem_addr_o); else pass_cnt++;
            end
            if (k > 0) begin
                chk_cnt++; if (rdata_o !== rd) $display("FAIL contention_rdata cyc=%0d got=%h exp=%h", k, rdata_o, rd); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        addr_i[0 +: AW] = 32'h1002_0004;
        we_i            = 2'b00;
        req_i           = 2'b01;
        #1;
        chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL single_gnt got=%b exp=01", gnt_o); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== 32'h1002_0004) $display("FAIL single_addr got=%h exp=10020004", mem_addr_o); else pass_cnt++;
        chk_cnt++; if (mem_we_o !== 1'b0) $display("FAIL single_we got=%b exp=0", mem_we_o); else pass_cnt++;
        next_cycle();
        req_i       = 2'b00;
        mem_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk_cnt++; if (rvalid_o !== 2'b01) $display("FAIL single_rvalid got=%b exp=01", rvalid_o); else pass_cnt++;
        chk_cnt++; if (rdata_o !== 32'hDEAD_BEEF) $display("FAIL single_rdata got=%h exp=deadbeef", rdata_o); else pass_cnt++;
        chk_cnt++; if (mem_req_o !== 1'b0) $display("FAIL single_idle_req got=%b exp=0", mem_req_o); else pass_cnt++;
        next_cycle();
        addr_i[0 +: AW] = A0;
        #1;
        chk_cnt++; if (rvalid_o !== 2'b00) $display("FAIL single_rvalid_clear got=%b exp=00", rvalid_o); else pass_cnt++;
    endtask

    // rr_ptr is 1 on entry; requester 1 locks for three beats, releasing on the third.
    task automatic test_lock();
        logic [1:0] exp_gnt [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        logic [1:0] exp_rv  [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [1:0] rq      [5] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
        logic [1:0] lk      [5] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
        for (int k = 0; k < 5; k++) begin
            req_i  = rq[k];
            lock_i = lk[k];
            #1;
            chk_cnt++; if (gnt_o !== exp_gnt[k]) $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", k, gnt_o, exp_gnt[k]); else pass_cnt++;
            chk_cnt++; if (rvalid_o !== exp_rv[k]) $display("FAIL lock_rvalid cyc=%0d got=%b exp=%b", k, rvalid_o, exp_rv[k]); else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_lock_max();
        logic [1:0] exp;
        for (int k = 0; k < 17; k++) begin
            req_i  = 2'b11;
            lock_i = 2'b10;
            exp    = (k < 16) ? 2'b10 : 2'b01;
            #1;
            chk_cnt++; if (gnt_o !== exp) $display("FAIL lockmax_gnt beat=%0d got=%b exp=%b", k, gnt_o, exp); else pass_cnt++;
            next_cycle();
        end
        req_i  = 2'b00;
        lock_i = 2'b00;
        #1;
        chk_cnt++; if (rvalid_o !== 2'b01) $display("FAIL lockmax_rvalid got=%b exp=01", rvalid_o); else pass_cnt++;
        next_cycle();
    endtask

    // rr_ptr is 1 on entry, so requester 1 owns the stalled request.
    task automatic test_stall();
        req_i     = 2'b11;
        mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_cnt++; if (mem_req_o !== 1'b1) $display("FAIL stall_req cyc=%0d got=%b exp=1", k, mem_req_o); else pass_cnt++;
            chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL stall_gnt cyc=%0d got=%b exp=00", k, gnt_o); else pass_cnt++;
            chk_cnt++; if (mem_addr_o !== A1) $display("FAIL stall_addr cyc=%0d got=%h exp=%h", k, mem_addr_o, A1); else pass_cnt++;
            chk_cnt++; if (rvalid_o !== 2'b00) $display("FAIL stall_rvalid cyc=%0d got=%b exp=00", k, rvalid_o); else pass_cnt++;
            next_cycle();
        end
        mem_gnt_i = 1'b1;
        #1;
        chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL stall_release_gnt got=%b exp=10", gnt_o); else pass_cnt++;
        next_cycle();
        req_i = 2'b01;
        #1;
        chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL stall_next_gnt got=%b exp=01", gnt_o); else pass_cnt++;
        chk_cnt++; if (rvalid_o !== 2'b10) $display("FAIL stall_rvalid_after got=%b exp=10", rvalid_o); else pass_cnt++;
        next_cycle();
        req_i = 2'b00;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        req_i               = 2'b01;
        we_i                = 2'b01;
        be_i[0 +: BW]       = 4'b0011;
        addr_i[0 +: AW]     = 32'h1000_0010;
        wdata_i[0 +: DW]    = 32'h1234_5678;
        #1;
        chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL b2b_wr_gnt got=%b exp=01", gnt_o); else pass_cnt++;
        chk_cnt++; if (mem_we_o !== 1'b1) $display("FAIL b2b_wr_we got=%b exp=1", mem_we_o); else pass_cnt++;
        chk_cnt++; if (mem_be_o !== 4'b0011) $display("FAIL b2b_wr_be got=%b exp=0011", mem_be_o); else pass_cnt++;
        chk_cnt++; if (mem_wdata_o !== 32'h1234_5678) $display("FAIL b2b_wr_wdata got=%h exp=12345678", mem_wdata_o); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== 32'h1000_0010) $display("FAIL b2b_wr_addr got=%h exp=10000010", mem_addr_o); else pass_cnt++;
        next_cycle();
        we_i          = 2'b00;
        be_i[0 +: BW] = 4'b1111;
        mem_rdata_i   = 32'h0BAD_F00D;
        #1;
        chk_cnt++; if (mem_we_o !== 1'b0) $display("FAIL b2b_rd_we got=%b exp=0", mem_we_o); else pass_cnt++;
        chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL b2b_rd_gnt got=%b exp=01", gnt_o); else pass_cnt++;
        chk_cnt++; if (rvalid_o !== 2'b01) $display("FAIL b2b_wr_rvalid got=%b exp=01", rvalid_o); else pass_cnt++;
        chk_cnt++; if (rdata_o !== 32'h0BAD_F00D) $display("FAIL b2b_wr_rdata got=%h exp=0badf00d", rdata_o); else pass_cnt++;
        next_cycle();
        req_i       = 2'b00;
        mem_rdata_i = 32'hFEED_CAFE;
        #1;
        chk_cnt++; if (rvalid_o !== 2'b01) $display("FAIL b2b_rd_rvalid got=%b exp=01", rvalid_o); else pass_cnt++;
        chk_cnt++; if (rdata_o !== 32'hFEED_CAFE) $display("FAIL b2b_rd_rdata got=%h exp=feedcafe", rdata_o); else pass_cnt++;
        next_cycle();
        addr_i = {A1, A0};
    endtask

    // rr_ptr is 1 on entry; reset must return it to 0 so requester 0 wins first.
    task automatic test_reset_mid_lock();
        req_i  = 2'b11;
        lock_i = 2'b10;
        #1;
        chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL rstlock_gnt0 got=%b exp=10", gnt_o); else pass_cnt++;
        next_cycle();
        #1;
        chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL rstlock_gnt1 got=%b exp=10", gnt_o); else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++; if (rvalid_o !== 2'b10) $display("FAIL rstlock_pending got=%b exp=10", rvalid_o); else pass_cnt++;
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL rstlock_gnt got=%b exp=00", gnt_o); else pass_cnt++;
        chk_cnt++; if (rvalid_o !== 2'b00) $display("FAIL rstlock_rvalid got=%b exp=00", rvalid_o); else pass_cnt++;
        chk_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rstlock_mem_req got=%b exp=0", mem_req_o); else pass_cnt++;
        chk_cnt++; if (rdata_o !== 32'h0) $display("FAIL rstlock_rdata got=%h exp=0", rdata_o); else pass_cnt++;
        @(negedge clk);
        rst_n  = 1'b1;
        lock_i = 2'b00;
        #1;
        chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL rstlock_first_gnt got=%b exp=01", gnt_o); else pass_cnt++;
        chk_cnt++; if (mem_addr_o !== A0) $display("FAIL rstlock_first_addr got=%h exp=%h", mem_addr_o, A0); else pass_cnt++;
        next_cycle();
        req_i = 2'b00;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_lock();
        test_lock_max();
        test_stall();
        test_back_to_back();
        test_reset_mid_lock();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM port between NB_REQ requesters, e.g. core LSU path and debug module system-bus access into data memory.
- Uses a req/gnt/rvalid protocol on both sides.
- Round-robin arbitration, with an optional per-requester lock that holds the port for multi-beat sequences.
- Routes read data back to the winner with fixed one-cycle SRAM latency.

Parameters:
- NB_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- LOCK_MAX, 16, maximum consecutive grants to a locked requester before forced release.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NB_REQ  per-requester request.
- lock_i  in  NB_REQ  per-requester hold-port hint, sampled with req.
- addr_i  in  NB_REQ*ADDR_WIDTH  packed addresses, requester k at slice k.
- we_i  in  NB_REQ  write enable.
- be_i  in  NB_REQ*DATA_WIDTH/8  byte enables.
- wdata_i  in  NB_REQ*DATA_WIDTH  write data.
- gnt_o  out  NB_REQ  grant, one-hot or zero.
- rvalid_o  out  NB_REQ  response valid, one-hot or zero.
- rdata_o  out  DATA_WIDTH  response data, shared by all requesters.
- mem_req_o  out  1  SRAM request.
- mem_gnt_i  in  1  SRAM accepts request this cycle.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after an accepted request.

Behaviour:
- Reset values:
  - gnt_o=0, rvalid_o=0, rdata_o=0, mem_req_o=0.
  - rr_ptr=0, state=IDLE, lock_cnt=0, resp_pending=0, resp_id=0.
- Arbitration is combinational in the request cycle:
  - winner = first requester with req_i set, searching from rr_ptr upward and wrapping modulo NB_REQ.
  - mem_req_o = |req_i in IDLE; in LOCKED, mem_req_o = req_i[owner].
  - mem_addr_o/we/be/wdata are muxed from the winner; they are 0 when there is no request.
- gnt_o[winner] = mem_req_o & mem_gnt_i. A requester holds req_i and its payload stable until granted.
- Accept = any gnt_o bit set. On accept:
  - resp_pending<=1, resp_id<=winner.
  - Next cycle: rvalid_o[resp_id]=1 and rdata_o=mem_rdata_i for reads and for writes. rdata_o is don't-care for writes but must equal mem_rdata_i.
  - Back-to-back accepts give rvalid on consecutive cycles. Throughput is one transfer per cycle.
- Round-robin pointer:
  - On accept in IDLE with lock_i[winner]=0: rr_ptr <= (winner+1) mod NB_REQ.
  - No accept: rr_ptr unchanged.
- State machine {IDLE, LOCKED}:
  - IDLE -> LOCKED on accept with lock_i[winner]=1; owner<=winner, lock_cnt<=1.
  - In LOCKED only the owner is considered. Other requests wait; their gnt stays 0.
  - LOCKED, each owner accept: lock_cnt++.
  - LOCKED -> IDLE when any of the following holds:
    - An owner accept with lock_i[owner]=0; that final beat is still granted.
    - req_i[owner]=0 for one cycle.
    - lock_cnt reaches LOCK_MAX on an accept.
  - On LOCKED exit, rr_ptr <= (owner+1) mod NB_REQ. This guarantees fairness.
  - lock_cnt saturates; it never wraps.
- mem_gnt_i=0 stalls: no gnt, pointer and state unchanged, mem_req_o stays asserted with the same winner.
  - The winner is recomputed each cycle from current req_i. Since granted requesters may not drop req, the winner only changes if a requester nearer rr_ptr raises req.
- Simultaneous accept and response: legal and required (pipelined). resp_pending is 1 if an accept occurs this cycle, else 0.
- Reset mid-operation (rst_n low asynchronously):
  - All outputs go to reset values immediately; an in-flight rvalid is dropped.
  - Requesters restart after reset.
- Invariants:
  - gnt_o and rvalid_o are each one-hot or zero.
  - At most one response is outstanding per cycle.

Test Plan:
- Single requester: req_i=01, addr 0x1002_0004, read, mem_gnt_i=1 → gnt_o=01 in the same cycle; next cycle rvalid_o=01, rdata_o=mem_rdata_i (0xDEADBEEF).
- Contention, NB_REQ=2: both req held for 4 cycles, no lock, rr_ptr=0 → grants 01,10,01,10; rvalid follows one cycle later with the matching ids.
- Lock: req1 asserts lock_i=1 for 3 beats while req0 is also pending → gnt 10,10,10 then 01. With lock_i=1 held continuously and LOCK_MAX=16, req0 is granted after the 16th req1 beat.
- Stall: mem_gnt_i=0 for 3 cycles with req_i=11 → mem_req_o=1, gnt_o=00, addr stays that of the rr_ptr winner; grant issues on the first cycle mem_gnt_i=1.
- Back-to-back write then read by requester 0 (write be=4'b0011 to 0x1000_0010, then read) → mem_we_o 1 then 0, mem_be_o=0011 on the write beat, rvalid_o=01 on two consecutive cycles.
- Reset mid-lock: assert rst_n=0 while LOCKED with a response pending → gnt_o, rvalid_o and mem_req_o are 0 immediately; after release, the first arbitration starts from rr_ptr=0.
